// File: rtl/load_down_counter.sv
// load_down_counter: loadable down counter/timer with one-shot or periodic terminal-count pulse.
module load_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    input  logic             restart,
    input  logic             enable,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc_pulse,
    output logic             running,
    output logic             expired
);
    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] reload_reg, reload_n, count_n;
    logic tc_n;
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            reload_reg <= '0;
            tc_pulse   <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            reload_reg <= reload_n;
            tc_pulse   <= tc_n;
        end
    end
    // load > clear > restart > decrement; every non-terminal edge drops tc_pulse
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload_reg;
        tc_n     = 1'b0;
        if (load) begin
            count_n  = load_value;
            reload_n = load_value;
            state_n  = (load_value != '0) ? RUN : IDLE;
        end else if (clear) begin
            count_n = '0;
            state_n = IDLE;
        end else if (restart) begin
            count_n = reload_reg;
            state_n = (reload_reg != '0) ? RUN : IDLE;
        end else if (state == RUN && enable) begin
            if (count > WIDTH'(1)) begin
                count_n = count - WIDTH'(1);
            end else begin
                tc_n    = 1'b1;
                count_n = auto_reload ? reload_reg : '0;
                state_n = auto_reload ? RUN : EXPIRED;
            end
        end
    end
    assign zero    = (count == '0);
    assign running = (state == RUN);
    assign expired = (state == EXPIRED);
endmodule
